// File: rtl/arith_share_arbiter_if.sv
// Requester/arithmetic-unit side bundle of the shared-unit arbiter.
// The master side drives requests and unit completion; the slave side is the arbiter.
interface arith_share_arbiter_if #(parameter int DW = 8);
    logic [3:0]      req;
    logic [4*DW-1:0] req_a;
    logic [4*DW-1:0] req_b;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            unit_start;
    logic [DW-1:0]   unit_a;
    logic [DW-1:0]   unit_b;
    logic            unit_done;
    logic [DW-1:0]   unit_result;
    logic [3:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;

    modport master (
        output req, req_a, req_b, unit_done, unit_result,
        input  gnt, sel, unit_start, unit_a, unit_b, rsp_valid, rsp_data, rsp_err, busy
    );
    modport slave (
        input  req, req_a, req_b, unit_done, unit_result,
        output gnt, sel, unit_start, unit_a, unit_b, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/arith_share_arbiter.sv
// Round-robin share of one multicycle arithmetic unit among 4 requesters; ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency req->unit_start 1 cycle, unit_done->rsp_valid 1 cycle; requesters hold req until their rsp_valid.
module arith_share_arbiter #(
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arith_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [3:0]    gnt_q;
    logic [1:0]    sel_q;
    logic          start_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [3:0]    rsp_vld_q;
    logic [DW-1:0] rsp_dat_q;
    logic          busy_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
`endif

    logic [1:0] win_d;
    logic       win_vld_d;

    // Scan from the farthest offset down so the closest set bit after ptr wins.
    always_comb begin
        win_d     = ptr_q;
        win_vld_d = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                win_d     = ptr_q + 2'(k);
                win_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            start_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        gnt_q   <= 4'b0001 << win_d;
                        sel_q   <= win_d;
                        a_q     <= bus.req_a[win_d*DW +: DW];
                        b_q     <= bus.req_b[win_d*DW +: DW];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_WAIT: begin
                    // A done arriving together with the timeout still wins.
                    if (bus.unit_done) begin
                        rsp_dat_q <= bus.unit_result;
                        rsp_vld_q <= gnt_q;
                        ptr_q     <= sel_q + 2'd1;
                        state_q   <= S_RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_dat_q <= '0;
                        rsp_vld_q <= gnt_q;
                        ptr_q     <= sel_q + 2'd1;
                        err_q     <= 1'b1;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                S_RESP: begin
                    rsp_vld_q <= '0;
                    gnt_q     <= '0;
                    sel_q     <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.unit_start = start_q;
    assign bus.unit_a     = a_q;
    assign bus.unit_b     = b_q;
    assign bus.rsp_valid  = rsp_vld_q;
    assign bus.rsp_data   = rsp_dat_q;
    assign bus.busy       = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.rsp_err    = err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif
endmodule
